// File: rtl/inpass_cfg_sequencer_pkg.sv
// Shared types and helpers for the InPass4 configuration sequencer.
package inpass_cfg_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD, ERR} cfgState_e;

   localparam int PINS_PER_BEL = 4;

   function automatic int frameIndex(input int bel, input int pin, input int frameBits);
      return (PINS_PER_BEL * bel + pin) / frameBits;
   endfunction

endpackage

// File: rtl/inpass_cfg_sequencer_if.sv
// Command handshake and frame bus between the configuration controller and the sequencer.
interface inpass_cfg_sequencer_if
   import inpass_cfg_pkg::*;
#(
   parameter int NUM_BELS   = 16,
   parameter int FRAME_BITS = 32
);
   localparam int SHADOW_W   = NUM_BELS * PINS_PER_BEL;
   localparam int NUM_FRAMES = (SHADOW_W + FRAME_BITS - 1) / FRAME_BITS;
   localparam int BEL_W      = $clog2(NUM_BELS) + 1;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_all;
   logic [BEL_W-1:0]      cmd_bel;
   logic [3:0]            cmd_mask;
   logic [3:0]            cmd_mode;
   logic [FRAME_BITS-1:0] FrameData;
   logic [NUM_FRAMES-1:0] FrameStrobe;
   logic                  done;
   logic                  err;
   logic [SHADOW_W-1:0]   cfg_shadow;

   modport master (
      output cmd_valid, cmd_all, cmd_bel, cmd_mask, cmd_mode,
      input  cmd_ready, FrameData, FrameStrobe, done, err, cfg_shadow
   );

   modport slave (
      input  cmd_valid, cmd_all, cmd_bel, cmd_mask, cmd_mode,
      output cmd_ready, FrameData, FrameStrobe, done, err, cfg_shadow
   );

endinterface

// File: rtl/inpass_cfg_sequencer_frame_writer.sv
// Drives one configuration frame through LOAD / STROBE / HOLD; a start seen in HOLD chains the next frame.
module frame_writer
   import inpass_cfg_pkg::*;
#(
   parameter int FRAME_BITS = 32,
   parameter int NUM_FRAMES = 2,
   parameter int FIDX_W     = 1
)(
   input  logic                  UserCLK,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [FIDX_W-1:0]     frameSel,
   input  logic [FRAME_BITS-1:0] frameIn,
   output logic [FRAME_BITS-1:0] FrameData,
   output logic [NUM_FRAMES-1:0] FrameStrobe,
   output logic                  lastCycle
);

   cfgState_e             wrState;
   logic [FIDX_W-1:0]     selReg;
   logic [NUM_FRAMES-1:0] strobeHot;

   always_comb begin
      strobeHot = '0;
      for (int f = 0; f < NUM_FRAMES; f++)
         strobeHot[f] = (int'(selReg) == f);
   end

   assign lastCycle = (wrState == HOLD);

   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         wrState     <= IDLE;
         selReg      <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
      end else begin
         case (wrState)
            IDLE: begin
               if (start) begin
                  wrState   <= LOAD;
                  selReg    <= frameSel;
                  FrameData <= frameIn;
               end
            end
            LOAD: begin
               wrState     <= STROBE;
               FrameStrobe <= strobeHot;
            end
            STROBE: begin
               wrState     <= HOLD;
               FrameStrobe <= '0;
            end
            HOLD: begin
               // Data only ever changes here or on leaving IDLE, both with the strobe low.
               if (start) begin
                  wrState   <= LOAD;
                  selReg    <= frameSel;
                  FrameData <= frameIn;
               end else begin
                  wrState   <= IDLE;
                  FrameData <= '0;
               end
            end
            default: begin
               wrState     <= IDLE;
               FrameData   <= '0;
               FrameStrobe <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/inpass_cfg_sequencer.sv
// Holds the InPass4 mode shadow, decodes commands and iterates the frames handed to frame_writer.
module inpass_cfg_sequencer
   import inpass_cfg_pkg::*;
#(
   parameter int NUM_BELS   = 16,
   parameter int FRAME_BITS = 32
)(
   input  logic                  UserCLK,
   input  logic                  resetn,
   inpass_cfg_sequencer_if.slave bus
);

   localparam int SHADOW_W   = NUM_BELS * PINS_PER_BEL;
   localparam int NUM_FRAMES = (SHADOW_W + FRAME_BITS - 1) / FRAME_BITS;
   localparam int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   // Top level only uses IDLE / LOAD / ERR; LOAD spans the whole frame sequence.
   cfgState_e                      seqState;
   logic [SHADOW_W-1:0]            shadow;
   logic [SHADOW_W-1:0]            shadowNext;
   logic                           allMode;
   logic [FIDX_W-1:0]              frameIdx;
   logic [FIDX_W-1:0]              startIdx;
   logic [FIDX_W-1:0]              wrSel;
   logic [FRAME_BITS-1:0]          wrData;
   logic [NUM_FRAMES*FRAME_BITS-1:0] framesFlat;
   logic                           accept;
   logic                           belOk;
   logic                           moreFrames;
   logic                           wrStart;
   logic                           wrLast;

   assign bus.cmd_ready  = (seqState == IDLE);
   assign bus.cfg_shadow = shadow;
   assign accept         = bus.cmd_valid && bus.cmd_ready;
   assign belOk          = (int'(bus.cmd_bel) < NUM_BELS);
   assign moreFrames     = allMode && (int'(frameIdx) < NUM_FRAMES - 1);
   assign bus.err        = (seqState == ERR);
   assign bus.done       = (seqState == ERR) || ((seqState == LOAD) && wrLast && !moreFrames);

   always_comb begin
      shadowNext = shadow;
      if (accept && !bus.cmd_all && belOk) begin
         for (int k = 0; k < PINS_PER_BEL; k++)
            if (bus.cmd_mask[k])
               shadowNext[int'(bus.cmd_bel) * PINS_PER_BEL + k] = bus.cmd_mode[k];
      end
   end

   always_comb begin
      startIdx = '0;
      if (!bus.cmd_all)
         startIdx = FIDX_W'(frameIndex(int'(bus.cmd_bel), 0, FRAME_BITS));
   end

   // Frames are cut from the post-update shadow so a command's own edit is written out.
   always_comb begin
      framesFlat                 = '0;
      framesFlat[SHADOW_W-1:0]   = shadowNext;
      wrStart                    = 1'b0;
      wrSel                      = startIdx;
      if (seqState == IDLE) begin
         wrStart = accept && (bus.cmd_all || belOk);
      end else if ((seqState == LOAD) && wrLast && moreFrames) begin
         wrStart = 1'b1;
         wrSel   = frameIdx + 1'b1;
      end
      wrData = framesFlat[int'(wrSel) * FRAME_BITS +: FRAME_BITS];
   end

   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         seqState <= IDLE;
         shadow   <= '0;
         allMode  <= 1'b0;
         frameIdx <= '0;
      end else begin
         case (seqState)
            IDLE: begin
               if (accept) begin
                  shadow   <= shadowNext;
                  allMode  <= bus.cmd_all;
                  frameIdx <= startIdx;
                  seqState <= (bus.cmd_all || belOk) ? LOAD : ERR;
               end
            end
            LOAD: begin
               if (wrLast) begin
                  if (moreFrames)
                     frameIdx <= frameIdx + 1'b1;
                  else
                     seqState <= IDLE;
               end
            end
            ERR:     seqState <= IDLE;
            default: seqState <= IDLE;
         endcase
      end
   end

   frame_writer #(
      .FRAME_BITS (FRAME_BITS),
      .NUM_FRAMES (NUM_FRAMES),
      .FIDX_W     (FIDX_W)
   ) uWriter (
      .UserCLK     (UserCLK),
      .resetn      (resetn),
      .start       (wrStart),
      .frameSel    (wrSel),
      .frameIn     (wrData),
      .FrameData   (bus.FrameData),
      .FrameStrobe (bus.FrameStrobe),
      .lastCycle   (wrLast)
   );

endmodule

// File: tb/tb_inpass_cfg_sequencer.sv
// Directed bench for inpass_cfg_sequencer with hand-computed per-cycle expectations.
module tb_inpass_cfg_sequencer;
   import inpass_cfg_pkg::*;

   localparam int NUM_BELS   = 16;
   localparam int FRAME_BITS = 32;

   logic UserCLK = 1'b0;
   logic resetn  = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   inpass_cfg_sequencer_if #(.NUM_BELS(NUM_BELS), .FRAME_BITS(FRAME_BITS)) bus();

   inpass_cfg_sequencer #(.NUM_BELS(NUM_BELS), .FRAME_BITS(FRAME_BITS)) dut (
      .UserCLK (UserCLK),
      .resetn  (resetn),
      .bus     (bus.slave)
   );

   always #5 UserCLK = ~UserCLK;

   task automatic tick();
      @(posedge UserCLK);
      #1;
   endtask

   // Present a command for exactly one edge; returns sampling cycle T+1.
   task automatic issue(input logic all, input logic [4:0] bel, input logic [3:0] mask, input logic [3:0] mode);
      bus.cmd_all   = all;
      bus.cmd_bel   = bel;
      bus.cmd_mask  = mask;
      bus.cmd_mode  = mode;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
      checks++; if (bus.FrameData !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.FrameData); end
      checks++; if (bus.FrameStrobe !== 2'b00) begin errors++; $display("FAIL reset_strobe got %b want 00", bus.FrameStrobe); end
      checks++; if ({bus.done, bus.err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got %b want 00", {bus.done, bus.err}); end
      checks++; if (bus.cfg_shadow !== 64'h0) begin errors++; $display("FAIL reset_shadow got %h want 0", bus.cfg_shadow); end
   endtask

   task automatic test_single(input string name, input logic [4:0] bel, input logic [3:0] mask,
                              input logic [3:0] mode, input logic [31:0] expData,
                              input logic [1:0] expStrobe, input logic [63:0] expShadow);
      logic [31:0] eData   [4];
      logic [1:0]  eStrobe [4];
      logic        eDone   [4];
      logic        eReady  [4];
      eData   = '{expData, expData, expData, 32'h0};
      eStrobe = '{2'b00, expStrobe, 2'b00, 2'b00};
      eDone   = '{1'b0, 1'b0, 1'b1, 1'b0};
      eReady  = '{1'b0, 1'b0, 1'b0, 1'b1};
      issue(1'b0, bel, mask, mode);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.FrameData !== eData[i] || bus.FrameStrobe !== eStrobe[i] ||
             bus.done !== eDone[i] || bus.cmd_ready !== eReady[i] || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s cyc T+%0d got data=%h strobe=%b done=%b ready=%b err=%b want data=%h strobe=%b done=%b ready=%b err=0",
                     name, i + 1, bus.FrameData, bus.FrameStrobe, bus.done, bus.cmd_ready, bus.err,
                     eData[i], eStrobe[i], eDone[i], eReady[i]);
         end
         if (i < 3) tick();
      end
      checks++;
      if (bus.cfg_shadow !== expShadow) begin
         errors++; $display("FAIL %s_shadow got %h want %h", name, bus.cfg_shadow, expShadow);
      end
   endtask

   task automatic test_cmd_all();
      logic [31:0] eData   [7];
      logic [1:0]  eStrobe [7];
      logic        eDone   [7];
      logic        eReady  [7];
      eData   = '{32'h0000A000, 32'h0000A000, 32'h0000A000, 32'h00000050, 32'h00000050, 32'h00000050, 32'h0};
      eStrobe = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
      eDone   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      eReady  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      issue(1'b1, 5'd31, 4'hF, 4'h0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (bus.FrameData !== eData[i] || bus.FrameStrobe !== eStrobe[i] ||
             bus.done !== eDone[i] || bus.cmd_ready !== eReady[i]) begin
            errors++;
            $display("FAIL cmd_all cyc T+%0d got data=%h strobe=%b done=%b ready=%b want data=%h strobe=%b done=%b ready=%b",
                     i + 1, bus.FrameData, bus.FrameStrobe, bus.done, bus.cmd_ready,
                     eData[i], eStrobe[i], eDone[i], eReady[i]);
         end
         if (i < 6) tick();
      end
      checks++;
      if (bus.cfg_shadow !== 64'h00000050_0000A000) begin
         errors++; $display("FAIL cmd_all_shadow got %h want 000000500000a000", bus.cfg_shadow);
      end
   endtask

   task automatic test_error(input logic [4:0] bel);
      issue(1'b0, bel, 4'hF, 4'hF);
      checks++;
      if ({bus.done, bus.err, bus.cmd_ready} !== 3'b110 || bus.FrameStrobe !== 2'b00) begin
         errors++;
         $display("FAIL err_bel%0d T+1 got done/err/ready=%b strobe=%b want 110 strobe=00",
                  bel, {bus.done, bus.err, bus.cmd_ready}, bus.FrameStrobe);
      end
      tick();
      checks++;
      if ({bus.done, bus.err, bus.cmd_ready} !== 3'b001 || bus.FrameStrobe !== 2'b00) begin
         errors++;
         $display("FAIL err_bel%0d T+2 got done/err/ready=%b strobe=%b want 001 strobe=00",
                  bel, {bus.done, bus.err, bus.cmd_ready}, bus.FrameStrobe);
      end
      checks++;
      if (bus.cfg_shadow !== 64'h00000050_0000A000) begin
         errors++; $display("FAIL err_bel%0d_shadow got %h want 000000500000a000", bel, bus.cfg_shadow);
      end
   endtask

   task automatic test_mid_reset();
      int strobes = 0;
      issue(1'b1, 5'd0, 4'h0, 4'h0);
      tick();
      checks++;
      if (bus.FrameStrobe !== 2'b01) begin
         errors++; $display("FAIL midrst_pre_strobe got %b want 01", bus.FrameStrobe);
      end
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++;
      if (bus.FrameStrobe !== 2'b00 || bus.FrameData !== 32'h0 || bus.cfg_shadow !== 64'h0 ||
          bus.done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after got strobe=%b data=%h shadow=%h done=%b err=%b want all 0",
                  bus.FrameStrobe, bus.FrameData, bus.cfg_shadow, bus.done, bus.err);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         strobes += $countones(bus.FrameStrobe);
      end
      checks++;
      if (strobes != 0 || bus.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_quiet got strobes=%0d ready=%b want 0 and 1", strobes, bus.cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      int   strobes = 0;
      int   dones   = 0;
      logic eReady;
      bus.cmd_all   = 1'b0;
      bus.cmd_bel   = 5'd1;
      bus.cmd_mask  = 4'hF;
      bus.cmd_mode  = 4'h1;
      bus.cmd_valid = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         strobes += $countones(bus.FrameStrobe);
         if (bus.done === 1'b1) dones++;
         eReady = (i == 4) || (i == 11) || (i == 15);
         checks++;
         if (bus.cmd_ready !== eReady) begin
            errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", i, bus.cmd_ready, eReady);
         end
         if (i == 1) begin
            bus.cmd_all = 1'b1;
         end else if (i == 5) begin
            bus.cmd_all  = 1'b0;
            bus.cmd_bel  = 5'd2;
            bus.cmd_mask = 4'h3;
            bus.cmd_mode = 4'h3;
         end else if (i == 12) begin
            bus.cmd_valid = 1'b0;
         end
      end
      checks++;
      if (strobes != 4) begin errors++; $display("FAIL b2b_strobes got %0d want 4", strobes); end
      checks++;
      if (dones != 3) begin errors++; $display("FAIL b2b_dones got %0d want 3", dones); end
      checks++;
      if (bus.cfg_shadow !== 64'h310) begin
         errors++; $display("FAIL b2b_shadow got %h want 310", bus.cfg_shadow);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_all   = 1'b0;
      bus.cmd_bel   = '0;
      bus.cmd_mask  = '0;
      bus.cmd_mode  = '0;
      test_reset();
      test_single("bel3", 5'd3, 4'hF, 4'hA, 32'h0000A000, 2'b01, 64'h00000000_0000A000);
      test_single("bel9", 5'd9, 4'h5, 4'hF, 32'h00000050, 2'b10, 64'h00000050_0000A000);
      test_cmd_all();
      test_single("mask0", 5'd0, 4'h0, 4'hF, 32'h0000A000, 2'b01, 64'h00000050_0000A000);
      test_error(5'd16);
      test_error(5'd31);
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
